// File: rtl/onehot_enc_qual.sv
// onehot_enc_qual: collapses a one-hot select vector back to its binary code.
// A candidate is accepted only after STABLE_CYCLES consecutive identical
// well-formed beats. The code is then held on a registered valid/ready output.
// Non-one-hot beats (zero or multi-hot) are dropped. Each one raises a
// one-cycle error pulse and bumps a saturating error counter.
//
// Ports:
//   Clock, Reset_n   rising-edge clock, asynchronous active-low reset
//   eq_in/in_valid   one-hot candidate and its valid
//   in_ready         combinational, low only while an output is held
//   code_out         binary index of the qualified bit
//   out_valid        code_out valid
//   out_ready        downstream accept
//   err_onehot       pulse: a malformed beat was accepted last cycle
//   err_count        saturating count of malformed beats
module onehot_enc_qual #(
  parameter  int WIDTH         = 4,
  parameter  int STABLE_CYCLES = 2,
  parameter  int ERR_CNT_W     = 8,
  localparam int CODE_W        = $clog2(WIDTH)
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  input  logic [WIDTH-1:0]     eq_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [CODE_W-1:0]    code_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 err_onehot,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CYCLES);

  typedef enum logic [1:0] {IDLE, QUAL, HOLD} state_t;

  state_t                 state, state_nx;
  logic [WIDTH-1:0]       cand, cand_nx;
  logic [CNT_W-1:0]       cnt, cnt_nx, cnt_inc;
  logic [CODE_W-1:0]      code_nx;
  logic                   ov_nx, err_nx;
  logic [ERR_CNT_W-1:0]   ecnt_nx;
  logic [WIDTH-1:0]       eq_m1;
  logic                   well_formed, accept;

  // OR of set-bit indices; only applied to one-hot vectors, so this is exact.
  function automatic logic [CODE_W-1:0] enc(input logic [WIDTH-1:0] v);
    logic [CODE_W-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++)
      if (v[i]) r = r | CODE_W'(i);
    return r;
  endfunction

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign eq_m1       = eq_in - WIDTH'(1);
  assign well_formed = (eq_in != '0) && ((eq_in & eq_m1) == '0);
  assign in_ready    = (state != HOLD);
  assign accept      = in_valid & in_ready;
  assign cnt_inc     = cnt + CNT_W'(1);

  always_comb begin
    state_nx = state;
    cand_nx  = cand;
    cnt_nx   = cnt;
    code_nx  = code_out;
    ov_nx    = out_valid;
    err_nx   = 1'b0;
    ecnt_nx  = err_count;
    case (state)
      IDLE, QUAL: begin
        if (accept && !well_formed) begin
          err_nx   = 1'b1;
          if (err_count != '1) ecnt_nx = err_count + ERR_CNT_W'(1);
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (accept && state == IDLE) begin
          cand_nx = eq_in;
          cnt_nx  = CNT_W'(1);
          if (STABLE_CYCLES == 1) begin
            code_nx  = enc(eq_in);
            ov_nx    = 1'b1;
            state_nx = HOLD;
          end else begin
            state_nx = QUAL;
          end
        end else if (accept) begin
          if (eq_in == cand) begin
            cnt_nx = cnt_inc;
            if (cnt_inc == STABLE_C) begin
              code_nx  = enc(cand);
              ov_nx    = 1'b1;
              state_nx = HOLD;
            end
          end else begin
            // A different clean select restarts qualification, not an error.
            cand_nx = eq_in;
            cnt_nx  = CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          ov_nx    = 1'b0;
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      cand       <= '0;
      cnt        <= '0;
      code_out   <= '0;
      out_valid  <= 1'b0;
      err_onehot <= 1'b0;
      err_count  <= '0;
    end else begin
      state      <= state_nx;
      cand       <= cand_nx;
      cnt        <= cnt_nx;
      code_out   <= code_nx;
      out_valid  <= ov_nx;
      err_onehot <= err_nx;
      err_count  <= ecnt_nx;
    end
  end

endmodule

// File: tb/tb_onehot_enc_qual.sv
// Directed bench for onehot_enc_qual (defaults WIDTH=4, STABLE_CYCLES=2).
// Inputs change 1ns after the rising edge; directed checks sample there too.
// A negedge monitor pops the expected-code queue on every out handshake.
module tb_onehot_enc_qual;

  logic       Clock = 1'b0;
  logic       Reset_n = 1'b0;
  logic [3:0] eq_in = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] code_out;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       err_onehot;
  logic [7:0] err_count;

  int n_pass = 0;
  int n_total = 0;
  logic [1:0] sb[$];

  onehot_enc_qual #(.WIDTH(4), .STABLE_CYCLES(2), .ERR_CNT_W(8)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .eq_in(eq_in), .in_valid(in_valid),
    .in_ready(in_ready), .code_out(code_out), .out_valid(out_valid),
    .out_ready(out_ready), .err_onehot(err_onehot), .err_count(err_count)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  // Handshake happens at the next rising edge; inputs are stable here.
  always @(negedge Clock) begin
    if (Reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_output", {30'd0, code_out}, 32'hdead);
      else chk("sb_code", {30'd0, code_out}, {30'd0, sb.pop_front()});
    end
  end

  initial begin
    // Reset
    cyc(); cyc();
    chk("rst_code", code_out, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_ecnt", err_count, 0);
    chk("rst_rdy", in_ready, 1);
    Reset_n = 1'b1;
    cyc();
    chk("rst_rel_rdy", in_ready, 1);

    // Clean encode: 0100 on cycles 0,1
    eq_in = 4'b0100; in_valid = 1; sb.push_back(2'b10);
    cyc();
    chk("enc_c1_ov", out_valid, 0);
    cyc();
    chk("enc_ov", out_valid, 1);
    chk("enc_code", code_out, 2);
    chk("enc_rdy", in_ready, 0);
    eq_in = 4'b0001;                    // ignored while holding
    cyc();
    in_valid = 0;
    cyc();
    chk("enc_hold_ov", out_valid, 1);
    chk("enc_hold_code", code_out, 2);
    out_ready = 1;
    cyc();
    out_ready = 0;
    chk("enc_drain_ov", out_valid, 0);
    chk("enc_drain_rdy", in_ready, 1);

    // Requalify: 0001 then 1000,1000
    eq_in = 4'b0001; in_valid = 1;
    cyc();
    eq_in = 4'b1000; sb.push_back(2'b11);
    cyc();
    chk("rq_no_ov", out_valid, 0);
    cyc();
    chk("rq_ov", out_valid, 1);
    chk("rq_code", code_out, 3);
    chk("rq_err", err_count, 0);
    in_valid = 0; out_ready = 1;
    cyc();
    out_ready = 0;

    // Malformed beats
    eq_in = 4'b0110; in_valid = 1;
    cyc();
    chk("mf_pulse", err_onehot, 1);
    chk("mf_cnt1", err_count, 1);
    chk("mf_ov", out_valid, 0);
    in_valid = 0;
    cyc();
    chk("mf_pulse_end", err_onehot, 0);
    eq_in = 4'b0000; in_valid = 1;
    cyc();
    chk("mf_cnt2", err_count, 2);
    in_valid = 0;
    cyc();
    chk("mf_no_ov", out_valid, 0);

    // Malformed beat mid-qualification drops the candidate
    eq_in = 4'b0100; in_valid = 1;
    cyc();
    eq_in = 4'b1100;
    cyc();
    eq_in = 4'b0100;
    cyc();
    chk("mfq_no_ov", out_valid, 0);
    chk("mfq_cnt", err_count, 3);
    sb.push_back(2'b10);
    cyc();
    chk("mfq_ov", out_valid, 1);
    in_valid = 0; out_ready = 1;
    cyc();
    out_ready = 0;

    // Gaps in in_valid keep qualification
    eq_in = 4'b0010; in_valid = 1;
    cyc();
    in_valid = 0;
    cyc(); cyc(); cyc();
    chk("gap_no_ov", out_valid, 0);
    in_valid = 1; sb.push_back(2'b01);
    cyc();
    chk("gap_ov", out_valid, 1);
    chk("gap_code", code_out, 1);
    in_valid = 0; out_ready = 1;
    cyc();
    out_ready = 0;

    // Saturation: 300 malformed beats starting from 3
    in_valid = 1;
    for (int i = 0; i < 300; i++) begin
      eq_in = (i % 2) ? 4'b1111 : 4'b0000;
      cyc();
      if (i == 249) chk("sat_mid", err_count, 253);
    end
    chk("sat_cnt", err_count, 255);
    chk("sat_pulse", err_onehot, 1);
    chk("sat_ov", out_valid, 0);
    in_valid = 0;
    cyc();

    // Async reset mid-QUAL
    eq_in = 4'b0100; in_valid = 1;
    cyc();
    in_valid = 0;
    #2 Reset_n = 0;
    #1;
    chk("async_ecnt", err_count, 0);
    chk("async_ov", out_valid, 0);
    #1 Reset_n = 1;
    cyc();
    in_valid = 1;
    cyc();
    in_valid = 0;
    cyc();
    chk("postrst_single", out_valid, 0);
    in_valid = 1; sb.push_back(2'b10);
    cyc();
    chk("postrst_two_ov", out_valid, 1);
    chk("postrst_code", code_out, 2);

    // Async reset mid-HOLD clears the held output without an edge
    in_valid = 0;
    #2 Reset_n = 0;
    #1;
    chk("hold_rst_ov", out_valid, 0);
    chk("hold_rst_code", code_out, 0);
    chk("hold_rst_rdy", in_ready, 1);
    void'(sb.pop_back());
    #1 Reset_n = 1;
    cyc(); cyc();
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
